// File: rtl/bcast_fifo_2r_if.sv
// Purpose: handshake bundle for the two-reader broadcast FIFO.
// Ports  : writer side in_valid/in_ready/in_data; per-reader out_valid_k,
//          out_ready_k, out_data_k and level_k (unread entry count).
interface bcast_fifo_2r_if #(
  parameter int WIDTH     = 256,
  parameter int LOG_DEPTH = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid_0;
  logic                 out_valid_1;
  logic                 out_ready_0;
  logic                 out_ready_1;
  logic [WIDTH-1:0]     out_data_0;
  logic [WIDTH-1:0]     out_data_1;
  logic [LOG_DEPTH:0]   level_0;
  logic [LOG_DEPTH:0]   level_1;

  // Writer and readers together, as seen from outside the FIFO.
  modport master (
    output in_valid, in_data, out_ready_0, out_ready_1,
    input  in_ready, out_valid_0, out_valid_1, out_data_0, out_data_1,
           level_0, level_1
  );

  // The FIFO itself.
  modport slave (
    input  in_valid, in_data, out_ready_0, out_ready_1,
    output in_ready, out_valid_0, out_valid_1, out_data_0, out_data_1,
           level_0, level_1
  );
endinterface

// File: rtl/bcast_fifo_2r.sv
// Purpose: broadcast FIFO; every accepted entry is delivered once to each of two readers.
// Latency: 1 cycle write->read, first-word fall-through on both readers.
// Backpressure: in_ready drops when either reader has DEPTH unread entries; readers drain independently.
// Ports  : CLK, CLR_N (sync active-low); bus.slave carries in_* write handshake,
//          out_*_k read handshake/data and level_k per reader.
module bcast_fifo_2r #(
  parameter int WIDTH     = 256,
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = $clog2(DEPTH)
) (
  input  logic            CLK,
  input  logic            CLR_N,
  bcast_fifo_2r_if.slave  bus
);

  localparam logic [LOG_DEPTH:0] PTR_ONE = (LOG_DEPTH+1)'(1);
  localparam logic [LOG_DEPTH:0] DEPTH_L = (LOG_DEPTH+1)'(DEPTH);

  // Storage is never reset; outputs only look at it while level_k != 0.
  logic [WIDTH-1:0]   mem [DEPTH];

  // Pointers carry one extra wrap bit so full (diff == DEPTH) and
  // empty (diff == 0) are distinguishable.
  logic [LOG_DEPTH:0] wptr;
  logic [LOG_DEPTH:0] rptr_0;
  logic [LOG_DEPTH:0] rptr_1;
  logic [LOG_DEPTH:0] level_0;
  logic [LOG_DEPTH:0] level_1;

  logic push;
  logic pop_0;
  logic pop_1;

  assign level_0 = wptr - rptr_0;
  assign level_1 = wptr - rptr_1;

  // Full is decided by the slower reader; a pop in the same cycle does not
  // free a slot for a push until the next cycle.
  assign bus.in_ready    = CLR_N && (level_0 < DEPTH_L) && (level_1 < DEPTH_L);
  assign bus.out_valid_0 = (level_0 != '0);
  assign bus.out_valid_1 = (level_1 != '0);
  assign bus.out_data_0  = mem[rptr_0[LOG_DEPTH-1:0]];
  assign bus.out_data_1  = mem[rptr_1[LOG_DEPTH-1:0]];
  assign bus.level_0     = level_0;
  assign bus.level_1     = level_1;

  assign push  = bus.in_valid && bus.in_ready;
  assign pop_0 = bus.out_valid_0 && bus.out_ready_0;
  assign pop_1 = bus.out_valid_1 && bus.out_ready_1;

  // Single write port; push already implies CLR_N high through in_ready.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wptr[LOG_DEPTH-1:0]] <= bus.in_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      wptr   <= '0;
      rptr_0 <= '0;
      rptr_1 <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop_0) begin
        rptr_0 <= rptr_0 + PTR_ONE;
      end
      if (pop_1) begin
        rptr_1 <= rptr_1 + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_bcast_fifo_2r.sv
// Purpose: directed self-checking bench for bcast_fifo_2r with a per-reader
//          expected-data queue; outputs are compared every cycle.
// Ports  : drives the master modport of bcast_fifo_2r_if, CLK and CLR_N.
module tb_bcast_fifo_2r;
  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int LD    = 3;

  logic CLK;
  logic CLR_N;

  bcast_fifo_2r_if #(.WIDTH(W), .LOG_DEPTH(LD)) bus ();

  bcast_fifo_2r #(.WIDTH(W), .DEPTH(DEPTH), .LOG_DEPTH(LD)) dut (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int n_vec;
  int n_err;
  int rx0;
  int rx1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance
  // the model with the handshakes the model itself predicts.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic r0,
                      input logic r1, input logic cn, input bit do_chk);
    logic m_rdy;
    logic push;
    logic pop0;
    logic pop1;
    bus.in_valid    = iv;
    bus.in_data     = id;
    bus.out_ready_0 = r0;
    bus.out_ready_1 = r1;
    CLR_N           = cn;
    #1;
    m_rdy = cn && (q0.size() < DEPTH) && (q1.size() < DEPTH);
    if (do_chk) begin
      chk("in_ready",    W'(bus.in_ready),    W'(m_rdy));
      chk("out_valid_0", W'(bus.out_valid_0), W'(q0.size() != 0));
      chk("out_valid_1", W'(bus.out_valid_1), W'(q1.size() != 0));
      chk("level_0",     W'(bus.level_0),     W'(q0.size()));
      chk("level_1",     W'(bus.level_1),     W'(q1.size()));
      if (q0.size() != 0) chk("out_data_0", bus.out_data_0, q0[0]);
      if (q1.size() != 0) chk("out_data_1", bus.out_data_1, q1[0]);
    end
    push = iv && m_rdy;
    pop0 = cn && r0 && (q0.size() != 0);
    pop1 = cn && r1 && (q1.size() != 0);
    @(posedge CLK);
    if (!cn) begin
      q0.delete();
      q1.delete();
    end else begin
      if (pop0) begin void'(q0.pop_front()); rx0++; end
      if (pop1) begin void'(q1.pop_front()); rx1++; end
      if (push) begin q0.push_back(id); q1.push_back(id); end
    end
    @(negedge CLK);
  endtask

  initial begin
    logic iv;
    logic acc;
    logic [W-1:0] nxt;
    n_vec = 0;
    n_err = 0;
    rx0 = 0;
    rx1 = 0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready_0 = 1'b0;
    bus.out_ready_1 = 1'b0;
    CLR_N = 1'b0;

    // Reset: state is unknown until the first edge with CLR_N low.
    @(negedge CLK);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h11, 1'b1, 1'b1, 1'b0, 1'b1);   // in_ready must be 0 in reset
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);       // idle after reset

    // Basic flow.
    step(1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);       // level 2, head A1
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);       // head A2
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Skewed reader: reader 1 stalls, reader 0 keeps up.
    for (int i = 0; i < 8; i++) step(1'b1, 32'hB0 + W'(i), 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'hEE, 1'b0, 1'b0, 1'b1, 1'b1);   // full: push ignored
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);       // one pop on reader 1
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);       // in_ready back to 1
    repeat (7) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Full with simultaneous push and pops.
    for (int i = 0; i < 8; i++) step(1'b1, 32'hC0 + W'(i), 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'hCF, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 32'hD0, 1'b0, 1'b0, 1'b1, 1'b1);   // level 7, push accepted
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (8) step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Wrap-around stream 0..19 with random readiness.
    rx0 = 0;
    rx1 = 0;
    nxt = '0;
    for (int c = 0; c < 400 && (nxt < 20 || q0.size() != 0 || q1.size() != 0); c++) begin
      iv  = (nxt < 20) && ($urandom_range(0, 3) != 0);
      acc = iv && (q0.size() < DEPTH) && (q1.size() < DEPTH);
      step(iv, nxt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      if (acc) nxt++;
    end
    chk("stream_sent", nxt, 32'd20);
    chk("stream_rx0", W'(rx0), 32'd20);
    chk("stream_rx1", W'(rx1), 32'd20);

    // Mid-stream reset with level_0 = 3, level_1 = 5.
    for (int i = 0; i < 5; i++) step(1'b1, 32'hE0 + W'(i), 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("pre_rst_level_0", W'(bus.level_0), 32'd3);
    chk("pre_rst_level_1", W'(bus.level_1), 32'd5);
    step(1'b1, 32'h99, 1'b1, 1'b1, 1'b0, 1'b1);   // pushes/pops ignored in reset
    step(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 1'b1);   // empty, ready, push 0x55
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("post_rst_data_0", bus.out_data_0, 32'h55);
    chk("post_rst_data_1", bus.out_data_1, 32'h55);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Empty pop on reader 0 must not move its pointer.
    repeat (4) step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1);       // head 0x77 on both
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
